// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, constants and helpers for the PS/2 receiver.
//   ps2_state_t     : receiver FSM state (IDLE, RECV)
//   PS2_FRAME_BITS  : bits per device-to-host frame (start, 8 data, parity, stop)
//   ps2_odd_parity  : parity bit value that makes data + parity odd
package ps2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises and deglitches the PS/2 clock and produces a
// one-cycle pulse after each accepted high-to-low transition.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  asynchronous active-low reset
//   kclk_i  in  raw PS/2 clock (asynchronous, idle high)
//   fall_o  out one-cycle pulse in the cycle after the filtered clock drops
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kclk_i,
  output logic fall_o
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_fclk;
  logic       r_fclk_d;
  logic [7:0] r_cnt;

  // The filtered level follows the synchronised input only after it has
  // disagreed for FILTER_LEN consecutive cycles; any agreeing cycle restarts
  // the count, so shorter glitches never reach fclk.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
      r_cnt    <= 8'd0;
    end else begin
      r_sync1  <= kclk_i;
      r_sync2  <= r_sync1;
      r_fclk_d <= r_fclk;
      if (r_sync2 == r_fclk) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == 8'(FILTER_LEN - 1)) begin
        r_fclk <= r_sync2;
        r_cnt  <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign fall_o = r_fclk_d & ~r_fclk;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with a one-entry holding register.
// Frames are start 0, 8 data bits LSB first, odd parity, stop 1, sampled on
// falling edges of the filtered keyboard clock.
// Ports:
//   clk_i         in  system clock
//   rst_i         in  asynchronous active-low reset
//   kclk_i        in  PS/2 clock (asynchronous, idle high)
//   kdata_i       in  PS/2 data (asynchronous, idle high)
//   scan_code_o   out last accepted scan code
//   valid_o       out scan_code_o holds an unread code
//   ack_i         in  consumer has read the code
//   overflow_o    out sticky: an unread code was overwritten
//   parity_err_o  out one-cycle pulse when a frame is rejected
//   busy_o        out a frame is in progress (FSM in RECV)
// Handshake: valid_o rises when a code is loaded; the consumer raises ack_i
// for one cycle while valid_o is high; valid_o drops the following cycle
// unless a new code is accepted in that same cycle. ack_i with valid_o low
// is ignored.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] scan_code_o,
  output logic       valid_o,
  input  logic       ack_i,
  output logic       overflow_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int TMO_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TMO_W      = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TMO_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  logic             w_fall;
  logic             r_kd1;
  logic             r_kd2;
  ps2_state_t       r_state;
  logic [3:0]       r_bitcnt;
  logic [9:0]       r_shreg;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_code;
  logic             r_valid;
  logic             r_ovf;
  logic             r_perr;

  logic [9:0]       w_frame;
  logic             w_last;
  logic             w_frame_ok;
  logic             w_accept;
  logic             w_reject;
  logic             w_ack;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .kclk_i (kclk_i),
    .fall_o (w_fall)
  );

  // Data needs only synchronising: it is sampled long after it settles,
  // because the clock path adds the filter delay.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_kd1 <= 1'b1;
      r_kd2 <= 1'b1;
    end else begin
      r_kd1 <= kdata_i;
      r_kd2 <= r_kd1;
    end
  end

  // Complete frame as it stands on the stop-bit edge:
  // [7:0] data, [8] parity, [9] stop.
  assign w_frame    = {r_kd2, r_shreg[9:1]};
  assign w_last     = (r_state == RECV) && w_fall && (r_bitcnt == LAST_BIT);
  assign w_frame_ok = (w_frame[8] == ps2_odd_parity(w_frame[7:0])) && w_frame[9];
  assign w_accept   = w_last && w_frame_ok;
  assign w_reject   = w_last && !w_frame_ok;
  assign w_ack      = ack_i && r_valid;

  // Receive FSM with bit counter, shift register and timeout counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_bitcnt <= 4'd0;
      r_shreg  <= 10'd0;
      r_tmo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          if (w_fall && !r_kd2) begin
            r_state  <= RECV;
            r_bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (w_fall) begin
            r_tmo   <= '0;
            r_shreg <= {r_kd2, r_shreg[9:1]};
            if (r_bitcnt == LAST_BIT) begin
              r_state  <= IDLE;
              r_bitcnt <= 4'd0;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else if (r_tmo == TMO_MAX) begin
            // Stalled frame: drop it without flagging an error.
            r_state  <= IDLE;
            r_bitcnt <= 4'd0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_bitcnt <= 4'd0;
        end
      endcase
    end
  end

  // Holding register. An accept in the same cycle as an ack replaces the
  // code the consumer just read, so it is not an overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_code  <= 8'h00;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_perr <= w_reject;
      if (w_accept) begin
        r_code  <= w_frame[7:0];
        r_valid <= 1'b1;
        if (r_valid && !ack_i) begin
          r_ovf <= 1'b1;
        end else if (w_ack) begin
          r_ovf <= 1'b0;
        end
      end else if (w_ack) begin
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign scan_code_o  = r_code;
  assign valid_o      = r_valid;
  assign overflow_o   = r_ovf;
  assign parity_err_o = r_perr;
  assign busy_o       = (r_state == RECV);

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receiver for the PS/2 keyboard serial interface, the device-to-host direction carried on the `kclk_i`/`kdata_i` pins of `riscv_unit`. It synchronises and deglitches the keyboard clock and samples 11-bit frames on its falling edges. Each frame is start 0, 8 data bits LSB first, odd parity, stop 1. Valid scan codes go into a one-entry holding register that the keyboard peripheral on the system bus reads with a valid/ack handshake.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `FILTER_LEN`, 8: number of consecutive equal `kclk` samples, in cycles, needed to accept a level change (range 2..255).
- `TIMEOUT_US`, 200: maximum gap between falling edges inside a frame. Timeout cycles = `CLK_FREQ_HZ/1_000_000*TIMEOUT_US`.
- `clk_i` input 1: system clock. One clock domain only.
- `rst_i` input 1: reset, asynchronous, active-low.
- `kclk_i` input 1: PS/2 clock from the keyboard, asynchronous, idle high.
- `kdata_i` input 1: PS/2 data from the keyboard, asynchronous, idle high.
- `scan_code_o` output 8: last accepted scan code.
- `valid_o` output 1: `scan_code_o` holds an unread code.
- `ack_i` input 1: consumer has read the code. Honoured only while `valid_o` is high.
- `overflow_o` output 1: sticky. An unread code was overwritten.
- `parity_err_o` output 1: one-cycle pulse when a frame is rejected.
- `busy_o` output 1: a frame is in progress (state RECV).

## Operation
- Front end:
  - `kclk_i` and `kdata_i` each pass through a 2-FF synchroniser. Synchroniser FFs reset to 1.
  - Filtered clock `fclk` (reset 1) takes the synchronised `kclk` value once it has been stable for `FILTER_LEN` consecutive cycles. Shorter pulses are ignored.
  - `fall` is a one-cycle pulse in the cycle after `fclk` goes 1→0.
- FSM, two states:
  - IDLE: on `fall` with synchronised `kdata`=0, go to RECV and set bit counter to 1. On `fall` with data 1, ignore the edge and stay in IDLE.
  - RECV: on each `fall`, shift synchronised `kdata` into a 10-bit shift register (LSB first) and increment the counter. On the counter-10 edge (stop bit), evaluate the frame and return to IDLE.
  - RECV timeout: if no `fall` arrives within the timeout count, return to IDLE and discard the frame silently (no error pulse). The timeout counter restarts on every `fall`.
- Frame evaluation:
  - A frame is accepted when XOR of the 8 data bits and the parity bit is 1, and the stop bit is 1.
  - Otherwise the frame is rejected: `parity_err_o` pulses and the holding register is unchanged. This also covers a bad stop bit.
- Holding register:
  - Accept with `valid_o`=0: load the code, set `valid_o`.
  - Accept with `valid_o`=1 and no ack in the same cycle: overwrite with the new code and set `overflow_o`.
  - Accept and ack in the same cycle: load the new code, `valid_o` stays 1, no overflow.
  - Ack without accept: clear `valid_o` and `overflow_o`. `scan_code_o` keeps its value.
- Multi-byte sequences (E0, F0 prefixes) are delivered byte by byte. No decoding is done here.

## Timing
- Reset values: `scan_code_o`=0x00, `valid_o`=0, `overflow_o`=0, `parity_err_o`=0, `busy_o`=0. FSM in IDLE, counters at 0, `fclk`=1.
- Reset asserted mid-frame aborts the frame immediately. After release, the next start bit on `fall` begins a fresh frame.
- Latency from a `kclk_i` falling edge to `fall`: 2 synchroniser cycles + `FILTER_LEN` cycles + 1 cycle.
- `kdata` is sampled in the `fall` cycle. Data must be stable at least `FILTER_LEN`+3 cycles after the `kclk` fall, which PS/2 timing guarantees.
- `valid_o`, `scan_code_o`, `overflow_o` and `parity_err_o` update in the cycle after the stop-bit `fall`.
- `valid_o` drops in the cycle after `ack_i` is sampled high.
- Timeout counter width is `$clog2` of the timeout count. It saturates and never wraps.

## Structure
- `ps2_pkg` holds:
  - the state enum `ps2_state_t` {IDLE, RECV};
  - `PS2_FRAME_BITS`=11;
  - the function `ps2_odd_parity(logic [7:0])`.
- Sub-module `ps2_clk_filter` contains the synchroniser, stability counter, `fclk` and the `fall` pulse. It is instantiated once for `kclk`; `kdata` uses only a bare 2-FF synchroniser.
- `ps2_rx` contains the FSM, shift register, bit counter, timeout counter and holding register.

## Test plan
- **Single code:** send 0x1C at a 10 kHz PS/2 clock (parity 0, stop 1) → `valid_o`=1, `scan_code_o`=0x1C, no `parity_err_o`; `ack_i` pulse → `valid_o`=0 next cycle.
- **Sequence with acks:** send E0, F0, 1C, 5C with parity bits 0, 1, 0, 1, acking after each → codes E0, F0, 1C, 5C delivered in order, `overflow_o` stays 0.
- **Bad parity:** send 0x1C with parity bit 1 → `parity_err_o` pulses once, `valid_o` stays 0, the following good 0x5C is accepted.
- **Overflow:** send 0x1C then 0x5C without ack → `scan_code_o`=0x5C, `overflow_o`=1; ack → both flags cleared.
- **Glitch and timeout:**
  - 3-cycle low glitch on `kclk_i` while idle → no state change.
  - Frame stopped after 4 bits for 300 µs → FSM returns to IDLE, no outputs change; the next full 0xF0 frame is received correctly.
- **Reset mid-frame:** assert `rst_i` low after bit 5 of a frame → all outputs at reset values, `busy_o`=0; a subsequent 0xE0 frame is received correctly.
